mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline. It sits between execute and writeback and registers the EX/MM bundle. It issues word-aligned data-memory requests for loads and stores, then stalls the pipeline until the memory responds. It also aligns and extends load data and produces the MM/WB bundle consumed by writeback and by execute's forwarding path.

---
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage; issues dmem requests, stalls until response, aligns load data.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned half/word accesses and raises misalign.
package rv32i_types;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_data_t;
  typedef struct packed {
    logic       valid;
    logic       mem_inst;
    logic       load;
    logic       regf_we;
    logic [2:0] funct3;
    logic [1:0] bottom_two;
    rvfi_data_t rvfi_data;
  } ex_mm_stage_reg_t;
  typedef ex_mm_stage_reg_t mm_wb_stage_reg_t;
endpackage

module mem_stage
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  ex_mm_stage_reg_t ex_mm,
  output ex_mm_stage_reg_t mm,
  output mm_wb_stage_reg_t mm_wb,
  output logic             stall,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;
  logic issued, issued_next, issue, bad, done;
  ex_mm_stage_reg_t mm_r;
  logic [7:0] lbyte;
  logic [15:0] lhalf;
  logic [31:0] ldata;

`ifdef MEM_MISALIGN_TRAP_EN
  assign bad = mm_r.valid & mm_r.mem_inst &
               ((mm_r.funct3[1:0] == 2'd1 & mm_r.bottom_two[0]) |
                (mm_r.funct3[1:0] == 2'd2 & |mm_r.bottom_two));
  assign misalign = bad;
`else
  assign bad = 1'b0;
`endif

  assign issue = mm_r.valid & mm_r.mem_inst & ~bad & (state == IDLE) & ~issued;
  assign done  = (state == WAIT) & dmem_resp;
  assign stall = issue | ((state == WAIT) & ~dmem_resp);
  assign mm    = mm_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      issued <= 1'b0;
      mm_r   <= '0;
    end else begin
      state  <= state_next;
      issued <= issued_next;
      if (!stall) mm_r <= ex_mm;
    end
  end

  always_comb begin
    state_next  = issue ? WAIT : done ? IDLE : state;
    issued_next = issue ? 1'b1 : done ? 1'b0 : issued;
  end

  assign dmem_addr  = issue ? {mm_r.rvfi_data.mem_addr[31:2], 2'b00} : '0;
  assign dmem_rmask = issue ? mm_r.rvfi_data.mem_rmask : '0;
  assign dmem_wmask = issue ? mm_r.rvfi_data.mem_wmask : '0;
  assign dmem_wdata = issue ? mm_r.rvfi_data.mem_wdata : '0;

  always_comb begin
    lbyte = 8'(dmem_rdata >> {mm_r.bottom_two, 3'b000});
    lhalf = 16'(dmem_rdata >> {mm_r.bottom_two[1], 4'b0000});
    ldata = (mm_r.funct3 == 3'b000) ? {{24{lbyte[7]}}, lbyte} :
            (mm_r.funct3 == 3'b100) ? {24'b0, lbyte} :
            (mm_r.funct3 == 3'b001) ? {{16{lhalf[15]}}, lhalf} :
            (mm_r.funct3 == 3'b101) ? {16'b0, lhalf} : dmem_rdata;
  end

  always_comb begin
    mm_wb = mm_r;
    mm_wb.valid = mm_r.valid & ~stall;
    mm_wb.rvfi_data.mem_rdata = dmem_rdata;
    if (mm_r.load) mm_wb.rvfi_data.rd_wdata = ldata;
    if (bad) begin
      mm_wb.regf_we = 1'b0;
      mm_wb.rvfi_data.mem_rmask = '0;
      mm_wb.rvfi_data.mem_wmask = '0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus for mem_stage with a transaction-level model checked every cycle.
module tb_mem_stage;
  import rv32i_types::*;
  logic clk = 0, rst = 1;
  ex_mm_stage_reg_t ex_mm, mm;
  mm_wb_stage_reg_t mm_wb;
  logic stall, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_rmask, dmem_wmask;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  int total = 0, bad = 0, rpulse = 0, wpulse = 0;
  bit chk_en = 0, e_issue, e_stall, m_wait = 0;
  ex_mm_stage_reg_t m_cur = '0;
  logic [31:0] got;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_mm(ex_mm), .mm(mm), .mm_wb(mm_wb), .stall(stall),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic ex_mm_stage_reg_t mk(bit mem, bit ld, logic [2:0] f3, logic [1:0] b,
      logic [31:0] base, logic [3:0] rm, logic [3:0] wm, logic [31:0] wd, logic [31:0] rdw);
    ex_mm_stage_reg_t x = '0;
    x.valid = 1; x.mem_inst = mem; x.load = ld; x.regf_we = !(mem && !ld);
    x.funct3 = f3; x.bottom_two = b;
    x.rvfi_data.mem_addr = base | {30'b0, b};
    x.rvfi_data.mem_rmask = rm; x.rvfi_data.mem_wmask = wm;
    x.rvfi_data.mem_wdata = wd; x.rvfi_data.rd_wdata = rdw;
    return x;
  endfunction

  function automatic bit mis(ex_mm_stage_reg_t x);
`ifdef MEM_MISALIGN_TRAP_EN
    return x.valid && x.mem_inst && ((x.funct3[1:0] == 1 && x.bottom_two[0]) ||
                                     (x.funct3[1:0] == 2 && x.bottom_two != 0));
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [1:0] b, logic [31:0] r);
    logic [31:0] byt, half;
    byt  = (r >> (8 * b)) & 32'hFF;
    half = (r >> (16 * b[1])) & 32'hFFFF;
    case (f3)
      3'd0: return byt >= 128 ? (byt | 32'hFFFFFF00) : byt;
      3'd4: return byt;
      3'd1: return half >= 32768 ? (half | 32'hFFFF0000) : half;
      3'd5: return half;
      default: return r;
    endcase
  endfunction

  // Model: an instruction either passes, or issues once and then waits for a response.
  always @(negedge clk) begin
    e_issue = m_cur.valid && m_cur.mem_inst && !m_wait && !mis(m_cur);
    e_stall = e_issue || (m_wait && !dmem_resp);
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("mm_valid", {31'b0, mm.valid}, {31'b0, m_cur.valid});
      chk("wb_valid", {31'b0, mm_wb.valid}, {31'b0, m_cur.valid && !e_stall});
      chk("rmask", {28'b0, dmem_rmask}, e_issue ? {28'b0, m_cur.rvfi_data.mem_rmask} : 0);
      chk("wmask", {28'b0, dmem_wmask}, e_issue ? {28'b0, m_cur.rvfi_data.mem_wmask} : 0);
      chk("addr", dmem_addr, e_issue ? (m_cur.rvfi_data.mem_addr & ~32'h3) : 0);
      chk("wdata", dmem_wdata, e_issue ? m_cur.rvfi_data.mem_wdata : 0);
      if (m_cur.valid && !e_stall)
        chk("rd_wdata", mm_wb.rvfi_data.rd_wdata, m_cur.load && !mis(m_cur) ?
            exp_load(m_cur.funct3, m_cur.bottom_two, dmem_rdata) : m_cur.rvfi_data.rd_wdata);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign", {31'b0, misalign}, {31'b0, mis(m_cur)});
`endif
      rpulse += (dmem_rmask != 0) ? 1 : 0;
      wpulse += (dmem_wmask != 0) ? 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cur = '0;
      m_wait = 0;
    end else begin
      if (e_issue) m_wait = 1;
      else if (m_wait && dmem_resp) m_wait = 0;
      if (!e_stall) m_cur = ex_mm;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // Presents op, then waits `waits` non-response cycles before responding with rdata.
  task automatic mem_op(ex_mm_stage_reg_t op, int waits, logic [31:0] rdata, output logic [31:0] rd);
    ex_mm = op; step();
    ex_mm = '0; mid();
    chk("issue_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      step(); mid();
      chk("wait_stall", {31'b0, stall}, 32'd1);
    end
    step(); dmem_resp = 1; dmem_rdata = rdata; mid();
    chk("resp_stall", {31'b0, stall}, 32'd0);
    rd = mm_wb.rvfi_data.rd_wdata;
    step(); dmem_resp = 0;
  endtask

  initial begin
    int r0, w0;
    ex_mm = '0; dmem_resp = 0; dmem_rdata = 0;
    step(); chk_en = 1; step(); rst = 0;
    mid();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_valid", {31'b0, mm_wb.valid}, 32'd0);

    // lb from byte 2 of 0x12803456 sign-extends 0x80
    r0 = rpulse;
    ex_mm = mk(1, 1, 3'd0, 2'd2, 32'h1000, 4'b0100, 0, 0, 0); step();
    ex_mm = '0; mid();
    chk("lb_rmask", {28'b0, dmem_rmask}, 32'h4);
    chk("lb_stall", {31'b0, stall}, 32'd1);
    step(); dmem_resp = 1; dmem_rdata = 32'h12803456; mid();
    chk("lb_stall2", {31'b0, stall}, 32'd0);
    chk("lb_data", mm_wb.rvfi_data.rd_wdata, 32'hFFFFFF80);
    step(); dmem_resp = 0;
    chk("lb_rpulse", rpulse - r0, 32'd1);

    // lhu from upper half, three stall cycles
    r0 = rpulse;
    mem_op(mk(1, 1, 3'd5, 2'd2, 32'h2000, 4'b1100, 0, 0, 0), 2, 32'hBEEF1234, got);
    chk("lhu_data", got, 32'h0000BEEF);
    chk("lhu_rpulse", rpulse - r0, 32'd1);

    // lh and lw variants
    mem_op(mk(1, 1, 3'd1, 2'd0, 32'h2100, 4'b0011, 0, 0, 0), 0, 32'h1234F00D, got);
    chk("lh_data", got, 32'hFFFFF00D);
    mem_op(mk(1, 1, 3'd2, 2'd0, 32'h2200, 4'b1111, 0, 0, 0), 1, 32'hCAFE0001, got);
    chk("lw_data", got, 32'hCAFE0001);
    mem_op(mk(1, 1, 3'd4, 2'd3, 32'h2300, 4'b1000, 0, 0, 0), 0, 32'h9A000000, got);
    chk("lbu_data", got, 32'h0000009A);

    // sw then add back to back
    w0 = wpulse;
    ex_mm = mk(1, 0, 3'd2, 2'd0, 32'h3000, 0, 4'hF, 32'hDEADBEEF, 0); step();
    ex_mm = mk(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h55); mid();
    chk("sw_stall", {31'b0, stall}, 32'd1);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    step(); dmem_resp = 1; mid();
    chk("sw_resp_stall", {31'b0, stall}, 32'd0);
    step(); dmem_resp = 0; ex_mm = '0; mid();
    chk("add_stall", {31'b0, stall}, 32'd0);
    chk("add_wb_valid", {31'b0, mm_wb.valid}, 32'd1);
    chk("add_rd", mm_wb.rvfi_data.rd_wdata, 32'h55);
    step();
    chk("sw_wpulse", wpulse - w0, 32'd1);

    // add, bubble, add, bubble, lw
    ex_mm = mk(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h11); step();
    ex_mm = '0; mid();
    chk("add1_stall", {31'b0, stall}, 32'd0);
    step(); mid();
    chk("bubble_wb", {31'b0, mm_wb.valid}, 32'd0);
    ex_mm = mk(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h22); step();
    ex_mm = '0; mid();
    chk("add2_rmask", {28'b0, dmem_rmask}, 32'd0);
    step();
    mem_op(mk(1, 1, 3'd2, 2'd0, 32'h4000, 4'hF, 0, 0, 0), 0, 32'h0BADF00D, got);
    chk("lw2_data", got, 32'h0BADF00D);

    // reset while waiting aborts the access; late response ignored
    ex_mm = mk(1, 1, 3'd2, 2'd0, 32'h5000, 4'hF, 0, 0, 0); step();
    ex_mm = '0; step(); rst = 1; mid();
    chk("wait_stall", {31'b0, stall}, 32'd1);
    step(); rst = 0; mid();
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_wb", {31'b0, mm_wb.valid}, 32'd0);
    step(); dmem_resp = 1; mid();
    chk("late_resp_stall", {31'b0, stall}, 32'd0);
    chk("late_resp_wb", {31'b0, mm_wb.valid}, 32'd0);
    step(); dmem_resp = 0; step();

`ifdef MEM_MISALIGN_TRAP_EN
    ex_mm = mk(1, 1, 3'd2, 2'd1, 32'h6000, 4'hF, 0, 0, 0); step();
    ex_mm = '0; mid();
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    chk("mis_rmask", {28'b0, dmem_rmask}, 32'd0);
    chk("mis_we", {31'b0, mm_wb.regf_we}, 32'd0);
    step(); step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
